// File: rtl/sequenced_cpu_core.sv
// rtl/sequenced_cpu_core.sv - parametrised fetch/execute core with handshake instruction fetch
//
// Purpose: two-phase core (FETCH, EXECUTE) with a HALTED state. Instructions
// are requested from an external memory of arbitrary latency. Each instruction
// is held in a local register while it executes. Register 0 is hard-wired to zero.
//
// Ports:
//   clock             sole clock, rising edge
//   isReset           synchronous active-high reset
//   switch            value loaded by LOADSWITCH
//   fetchRequest      high while waiting for an instruction
//   fetchAddress      address of the requested instruction (== pc)
//   instructionValid  instruction holds the word at fetchAddress
//   instruction       fetched word {opCode, registerOut, register1In, register2In, value}
//   pc                program counter
//   register1Value    contents of register 1
//   halted            core is in HALTED
//   retiredCount      saturating count of executed instructions since reset
module sequenced_cpu_core #(
  parameter int REGISTER_WIDTH      = 8,
  parameter int NUMBER_OF_REGISTERS = 8,
  parameter int PC_WIDTH            = 8,
  parameter int VALUE_WIDTH         = 8,
  parameter int INSTRUCTION_WIDTH   = 6 + 3 * $clog2(NUMBER_OF_REGISTERS) + VALUE_WIDTH
) (
  input  logic                         clock,
  input  logic                         isReset,
  input  logic [REGISTER_WIDTH-1:0]    switch,
  output logic                         fetchRequest,
  output logic [PC_WIDTH-1:0]          fetchAddress,
  input  logic                         instructionValid,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]          pc,
  output logic [REGISTER_WIDTH-1:0]    register1Value,
  output logic                         halted,
  output logic [15:0]                  retiredCount
);

  localparam int RA = $clog2(NUMBER_OF_REGISTERS);

  localparam logic [1:0] FETCH   = 2'd0;
  localparam logic [1:0] EXECUTE = 2'd1;
  localparam logic [1:0] HALTED  = 2'd2;

  localparam logic [5:0] OP_ADD        = 6'h01;
  localparam logic [5:0] OP_INC        = 6'h02;
  localparam logic [5:0] OP_DECREMENT  = 6'h03;
  localparam logic [5:0] OP_LSHIFT     = 6'h04;
  localparam logic [5:0] OP_RSHIFT     = 6'h05;
  localparam logic [5:0] OP_LOAD       = 6'h06;
  localparam logic [5:0] OP_LOADSWITCH = 6'h07;
  localparam logic [5:0] OP_JUMP       = 6'h10;
  localparam logic [5:0] OP_JUMPZERO   = 6'h11;
  localparam logic [5:0] OP_RESET      = 6'h3E;
  localparam logic [5:0] OP_HALT       = 6'h3F;

  logic [1:0]                  state;
  logic [INSTRUCTION_WIDTH-1:0] currentInstruction;
  logic [REGISTER_WIDTH-1:0]   regFile [NUMBER_OF_REGISTERS];

  logic [5:0]                  opCode;
  logic [RA-1:0]               registerOut;
  logic [RA-1:0]               register1In;
  logic [RA-1:0]               register2In;
  logic [VALUE_WIDTH-1:0]      value;

  assign opCode      = currentInstruction[INSTRUCTION_WIDTH-1 -: 6];
  assign registerOut = currentInstruction[VALUE_WIDTH+3*RA-1 -: RA];
  assign register1In = currentInstruction[VALUE_WIDTH+2*RA-1 -: RA];
  assign register2In = currentInstruction[VALUE_WIDTH+RA-1 -: RA];
  assign value       = currentInstruction[VALUE_WIDTH-1:0];

  // regFile[0] is never written, so it always reads as zero.
  logic [REGISTER_WIDTH-1:0] r1Value;
  logic [REGISTER_WIDTH-1:0] r2Value;
  assign r1Value = regFile[register1In];
  assign r2Value = regFile[register2In];

  logic                      writeEnable;
  logic [REGISTER_WIDTH-1:0] writeData;
  logic                      jumpTaken;
  logic [PC_WIDTH-1:0]       nextPc;
  logic                      softReset;

  always_comb begin
    writeEnable = 1'b0;
    writeData   = '0;
    jumpTaken   = 1'b0;
    case (opCode)
      OP_ADD:        begin writeEnable = 1'b1; writeData = r1Value + r2Value; end
      OP_INC:        begin writeEnable = 1'b1; writeData = r1Value + 1'b1; end
      OP_DECREMENT:  begin writeEnable = 1'b1; writeData = r1Value - 1'b1; end
      OP_LSHIFT:     begin writeEnable = 1'b1; writeData = {r1Value[REGISTER_WIDTH-2:0], 1'b0}; end
      OP_RSHIFT:     begin writeEnable = 1'b1; writeData = {1'b0, r1Value[REGISTER_WIDTH-1:1]}; end
      OP_LOAD:       begin writeEnable = 1'b1; writeData = REGISTER_WIDTH'(value); end
      OP_LOADSWITCH: begin writeEnable = 1'b1; writeData = switch; end
      OP_JUMP:       jumpTaken = 1'b1;
      OP_JUMPZERO:   jumpTaken = (r2Value == '0);
      default:       ;
    endcase
    nextPc = jumpTaken ? PC_WIDTH'(value) : pc + 1'b1;
  end

  assign softReset = (state == EXECUTE) && (opCode == OP_RESET);

  always_ff @(posedge clock) begin
    if (isReset || softReset) begin
      state              <= FETCH;
      pc                 <= '0;
      retiredCount       <= '0;
      currentInstruction <= '0;
      for (int i = 0; i < NUMBER_OF_REGISTERS; i++) regFile[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (instructionValid) begin
            currentInstruction <= instruction;
            state              <= EXECUTE;
          end
        end
        EXECUTE: begin
          if (writeEnable && (registerOut != '0)) regFile[registerOut] <= writeData;
          pc <= nextPc;
          if (retiredCount != 16'hFFFF) retiredCount <= retiredCount + 16'd1;
          state <= (opCode == OP_HALT) ? HALTED : FETCH;
        end
        default: ;  // HALTED: everything frozen until isReset
      endcase
    end
  end

  // Gated by isReset so the request drops during the reset cycle itself.
  assign fetchRequest   = (state == FETCH) && !isReset;
  assign fetchAddress   = pc;
  assign halted         = (state == HALTED);
  assign register1Value = regFile[1];

endmodule

// File: tb/tb_sequenced_cpu_core.sv
// tb/tb_sequenced_cpu_core.sv - directed self-checking bench for sequenced_cpu_core
module tb_sequenced_cpu_core;

  localparam int IW = 23;

  logic          clock;
  logic          isReset;
  logic [7:0]    switch;
  logic          fetchRequest;
  logic [7:0]    fetchAddress;
  logic          instructionValid;
  logic [IW-1:0] instruction;
  logic [7:0]    pc;
  logic [7:0]    register1Value;
  logic          halted;
  logic [15:0]   retiredCount;

  sequenced_cpu_core dut (
    .clock            (clock),
    .isReset          (isReset),
    .switch           (switch),
    .fetchRequest     (fetchRequest),
    .fetchAddress     (fetchAddress),
    .instructionValid (instructionValid),
    .instruction      (instruction),
    .pc               (pc),
    .register1Value   (register1Value),
    .halted           (halted),
    .retiredCount     (retiredCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory with programmable latency: valid after `latency` wait cycles.
  logic [IW-1:0] prog [256];
  int            latency;
  int            waitCount;

  always @(posedge clock) begin
    if (fetchRequest && !instructionValid) waitCount <= waitCount + 1;
    else waitCount <= 0;
  end

  assign instructionValid = fetchRequest && (waitCount >= latency);
  assign instruction      = prog[fetchAddress];

  int passed;
  int failed;
  int total;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [IW-1:0] mk(input logic [5:0] op, input logic [2:0] ro,
                                       input logic [2:0] ra, input logic [2:0] rb,
                                       input logic [7:0] v);
    return {op, ro, ra, rb, v};
  endfunction

  task automatic clearProg();
    for (int i = 0; i < 256; i++) prog[i] = '0;
  endtask

  // Holds reset for two cycles, then releases it on a falling edge.
  task automatic applyReset();
    isReset = 1'b1;
    cyc(2);
    isReset = 1'b0;
  endtask

  initial begin
    passed    = 0;
    failed    = 0;
    total     = 0;
    waitCount = 0;
    latency   = 0;
    switch    = 8'h5A;
    isReset   = 1'b1;
    clearProg();

    // Test 1: basic sequence, zero latency
    prog[0] = mk(6'h06, 3'd1, 3'd0, 3'd0, 8'h05);
    prog[1] = mk(6'h02, 3'd1, 3'd1, 3'd0, 8'h00);
    prog[2] = mk(6'h04, 3'd1, 3'd1, 3'd0, 8'h00);
    prog[3] = mk(6'h3F, 3'd0, 3'd0, 3'd0, 8'h00);
    cyc(2);
    check("rst_fetchRequest", fetchRequest, 0);
    check("rst_pc", pc, 0);
    check("rst_halted", halted, 0);
    check("rst_retired", retiredCount, 0);
    check("rst_r1", register1Value, 0);
    isReset = 1'b0;
    #1;
    check("post_rst_fetchRequest", fetchRequest, 1);
    cyc(1);
    check("exec_fetchRequest", fetchRequest, 0);
    cyc(1);
    check("t1_load", register1Value, 8'h05);
    cyc(2);
    check("t1_inc", register1Value, 8'h06);
    cyc(2);
    check("t1_lshift", register1Value, 8'h0C);
    check("t1_retired3", retiredCount, 3);
    cyc(2);
    check("t1_halted", halted, 1);
    check("t1_halt_pc", pc, 8'h04);
    check("t1_halt_retired", retiredCount, 4);
    cyc(5);
    check("t1_frozen_r1", register1Value, 8'h0C);
    check("t1_frozen_pc", pc, 8'h04);
    check("t1_frozen_fetch", fetchRequest, 0);

    // Test 2: wrap-around of arithmetic and pc
    clearProg();
    prog[0]   = mk(6'h06, 3'd1, 3'd0, 3'd0, 8'hFF);
    prog[1]   = mk(6'h02, 3'd1, 3'd1, 3'd0, 8'h00);
    prog[2]   = mk(6'h03, 3'd1, 3'd1, 3'd0, 8'h00);
    prog[3]   = mk(6'h10, 3'd0, 3'd0, 3'd0, 8'hFF);
    prog[255] = mk(6'h00, 3'd0, 3'd0, 3'd0, 8'h00);
    applyReset();
    cyc(2);
    check("t2_load_ff", register1Value, 8'hFF);
    cyc(2);
    check("t2_inc_wrap", register1Value, 8'h00);
    cyc(2);
    check("t2_dec_wrap", register1Value, 8'hFF);
    cyc(2);
    check("t2_jump_pc", pc, 8'hFF);
    cyc(2);
    check("t2_pc_wrap", pc, 8'h00);
    check("t2_retired", retiredCount, 5);

    // Test 3: three-cycle memory latency
    clearProg();
    prog[0] = mk(6'h06, 3'd1, 3'd0, 3'd0, 8'h33);
    prog[1] = mk(6'h02, 3'd1, 3'd1, 3'd0, 8'h00);
    prog[2] = mk(6'h3F, 3'd0, 3'd0, 3'd0, 8'h00);
    latency = 3;
    applyReset();
    cyc(3);
    check("t3_wait_fetch", fetchRequest, 1);
    check("t3_wait_pc", pc, 0);
    cyc(1);
    check("t3_exec_fetch", fetchRequest, 0);
    cyc(1);
    check("t3_first_r1", register1Value, 8'h33);
    check("t3_first_pc", pc, 1);
    check("t3_refetch", fetchRequest, 1);
    cyc(5);
    check("t3_second_r1", register1Value, 8'h34);
    check("t3_retired", retiredCount, 2);

    // Test 4: countdown loop ending in HALT
    clearProg();
    prog[0] = mk(6'h06, 3'd2, 3'd0, 3'd0, 8'h03);
    prog[1] = mk(6'h03, 3'd2, 3'd2, 3'd0, 8'h00);
    prog[2] = mk(6'h11, 3'd0, 3'd0, 3'd2, 8'h05);
    prog[3] = mk(6'h10, 3'd0, 3'd0, 3'd0, 8'h01);
    prog[5] = mk(6'h3F, 3'd0, 3'd0, 3'd0, 8'h00);
    latency = 0;
    applyReset();
    cyc(19);
    check("t4_not_yet_halted", halted, 0);
    cyc(1);
    check("t4_halted", halted, 1);
    check("t4_retired", retiredCount, 10);
    check("t4_pc", pc, 8'h06);
    cyc(5);
    check("t4_no_fetch", fetchRequest, 0);
    check("t4_pc_frozen", pc, 8'h06);
    check("t4_retired_frozen", retiredCount, 10);

    // Test 5: r0 write discard, unknown opcode, misc ops, soft reset
    clearProg();
    prog[0] = mk(6'h06, 3'd0, 3'd0, 3'd0, 8'hAA);
    prog[1] = mk(6'h06, 3'd1, 3'd0, 3'd0, 8'h11);
    prog[2] = mk(6'h01, 3'd1, 3'd1, 3'd0, 8'h00);
    prog[3] = mk(6'h20, 3'd1, 3'd1, 3'd1, 8'h99);
    prog[4] = mk(6'h07, 3'd1, 3'd0, 3'd0, 8'h00);
    prog[5] = mk(6'h05, 3'd1, 3'd1, 3'd0, 8'h00);
    prog[6] = mk(6'h01, 3'd1, 3'd1, 3'd1, 8'h00);
    prog[7] = mk(6'h3E, 3'd0, 3'd0, 3'd0, 8'h00);
    applyReset();
    cyc(6);
    check("t5_r0_reads_zero", register1Value, 8'h11);
    cyc(2);
    check("t5_unknown_r1", register1Value, 8'h11);
    check("t5_unknown_pc", pc, 8'h04);
    check("t5_unknown_retired", retiredCount, 4);
    cyc(2);
    check("t5_loadswitch", register1Value, 8'h5A);
    cyc(2);
    check("t5_rshift", register1Value, 8'h2D);
    cyc(2);
    check("t5_add", register1Value, 8'h5A);
    check("t5_retired7", retiredCount, 7);
    cyc(2);
    check("t5_soft_r1", register1Value, 0);
    check("t5_soft_pc", pc, 0);
    check("t5_soft_retired", retiredCount, 0);
    check("t5_soft_halted", halted, 0);
    check("t5_soft_fetch", fetchRequest, 1);

    // Test 6: hardware reset during a fetch wait and while HALTED
    clearProg();
    prog[0] = mk(6'h06, 3'd1, 3'd0, 3'd0, 8'h44);
    prog[1] = mk(6'h02, 3'd1, 3'd1, 3'd0, 8'h00);
    latency = 3;
    applyReset();
    cyc(7);
    check("t6_mid_wait_r1", register1Value, 8'h44);
    check("t6_mid_wait_fetch", fetchRequest, 1);
    isReset = 1'b1;
    cyc(1);
    check("t6_rst_r1", register1Value, 0);
    check("t6_rst_pc", pc, 0);
    check("t6_rst_retired", retiredCount, 0);
    check("t6_rst_fetch", fetchRequest, 0);
    isReset = 1'b0;
    #1;
    check("t6_restart_fetch", fetchRequest, 1);
    check("t6_restart_addr", fetchAddress, 0);

    clearProg();
    prog[0] = mk(6'h3F, 3'd0, 3'd0, 3'd0, 8'h00);
    latency = 0;
    applyReset();
    cyc(2);
    check("t6_halt_halted", halted, 1);
    check("t6_halt_pc", pc, 1);
    isReset = 1'b1;
    cyc(1);
    check("t6_unhalt_halted", halted, 0);
    check("t6_unhalt_pc", pc, 0);
    check("t6_unhalt_retired", retiredCount, 0);
    isReset = 1'b0;
    #1;
    check("t6_unhalt_fetch", fetchRequest, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
